// File: rtl/video_timing_gen.sv
// Raster timing generator with runtime-reprogrammable, frame-boundary double-buffered timing.
// All outputs are registered and advance one step per pixel enable.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int PIX_DIV  = 1,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_load,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          visible,
    output logic          line_start,
    output logic          frame_start
);

    typedef struct packed {
        logic [CW-1:0] ha, hfp, hs, hbp;
        logic [CW-1:0] va, vfp, vs, vbp;
    } timing_t;

    localparam timing_t TIM_DEF = '{
        ha: CW'(H_ACTIVE), hfp: CW'(H_FP), hs: CW'(H_SYNC), hbp: CW'(H_BP),
        va: CW'(V_ACTIVE), vfp: CW'(V_FP), vs: CW'(V_SYNC), vbp: CW'(V_BP)
    };

    localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    timing_t       live, shadow, cfg_in;
    logic [DW-1:0] div_cnt;
    logic          ce;
    logic [CW-1:0] h_pos, v_pos;
    logic [CW-1:0] h_total, v_total, h_sync_lo, h_sync_hi, v_sync_lo, v_sync_hi;
    logic          h_act, v_act, h_syn, v_syn, h_last, v_last, frame_end;
    logic          fields_ok, load_ok;

    assign cfg_in = '{
        ha: cfg_h_active, hfp: cfg_h_fp, hs: cfg_h_sync, hbp: cfg_h_bp,
        va: cfg_v_active, vfp: cfg_v_fp, vs: cfg_v_sync, vbp: cfg_v_bp
    };

    assign fields_ok = (cfg_in.ha != '0) && (cfg_in.hfp != '0) && (cfg_in.hs != '0) &&
                       (cfg_in.hbp != '0) && (cfg_in.va != '0) && (cfg_in.vfp != '0) &&
                       (cfg_in.vs != '0) && (cfg_in.vbp != '0);
    assign load_ok   = cfg_load && fields_ok;
    assign ce        = (div_cnt == DIV_LAST);

    // Region decode always uses the live set on the pre-increment position.
    always_comb begin
        h_total   = live.ha + live.hfp + live.hs + live.hbp;
        v_total   = live.va + live.vfp + live.vs + live.vbp;
        h_sync_lo = live.ha + live.hfp;
        h_sync_hi = h_sync_lo + live.hs;
        v_sync_lo = live.va + live.vfp;
        v_sync_hi = v_sync_lo + live.vs;
        h_act     = (h_pos < live.ha);
        v_act     = (v_pos < live.va);
        h_syn     = (h_pos >= h_sync_lo) && (h_pos < h_sync_hi);
        v_syn     = (v_pos >= v_sync_lo) && (v_pos < v_sync_hi);
        h_last    = (h_pos == h_total - CW'(1));
        v_last    = (v_pos == v_total - CW'(1));
        frame_end = ce && h_last && v_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= ce ? '0 : div_cnt + 1'b1;
            pix_ce  <= ce;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_pos <= '0;
            v_pos <= '0;
        end else if (ce) begin
            if (h_last) begin
                h_pos <= '0;
                v_pos <= v_last ? '0 : v_pos + CW'(1);
            end else begin
                h_pos <= h_pos + CW'(1);
            end
        end
    end

    // A load coinciding with the boundary lands in the shadow after the old shadow went live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live        <= TIM_DEF;
            shadow      <= TIM_DEF;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (frame_end && cfg_pending) live <= shadow;
            if (load_ok) shadow <= cfg_in;
            cfg_pending <= load_ok ? 1'b1 : (frame_end ? 1'b0 : cfg_pending);
            cfg_err     <= cfg_load && !fields_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            x           <= h_act ? h_pos : '0;
            y           <= v_act ? v_pos : '0;
            hsync       <= h_syn ? H_POL : ~H_POL;
            vsync       <= v_syn ? V_POL : ~V_POL;
            visible     <= h_act && v_act;
            line_start  <= (h_pos == '0);
            frame_start <= (h_pos == '0) && (v_pos == '0);
        end
    end

endmodule
